// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, sequencer state encoding and sigma helpers
// for the block sequencer and its message-schedule window.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INIT  = 3'd2,
    ST_PRE   = 3'd3,
    ST_ROUND = 3'd4,
    ST_FINAL = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_e;

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Small sigmas feed the schedule expansion; big sigmas belong to the round.
  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

endpackage

// File: rtl/sha256_block_sched_msg.sv
// Sixteen-word message-schedule window: loads W0..W15 from the bus, then
// expands W16..W63 in place, presenting W_t at the head.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_word,
  input  logic        shift_en,
  output logic [31:0] w_t
);

  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] w_new;

  // Loading and expansion share one shift path; only the tail source differs.
  always_comb begin
    w_new = small_sig1(win_q[14]) + win_q[9] + small_sig0(win_q[1]) + win_q[0];
    if (load_en || shift_en) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = load_en ? load_word : w_new;
    end else begin
      win_d = win_q;
    end
  end

  // Window storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'h0000_0000;
      end
    end else begin
      win_q <= win_d;
    end
  end

  assign w_t = win_q[0];

endmodule

// File: rtl/sha256_block_sched.sv
// SHA-256 block sequencer: accepts 16-word blocks, drives the compression
// datapath controls, W_t and K_t. Option: SHA256_SCHED_BSWAP_EN byte-reverses input words.
module sha256_block_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  input  logic        blk_first,
  input  logic        blk_last,
  output logic        dp_rst_n,
  output logic        in_vaild,
  output logic        compress_start,
  output logic        update_hash,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic        busy,
  output logic        digest_valid
);

  sched_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [5:0]   round_q, round_d;
  logic         first_q, first_d;
  logic         last_q, last_d;
  logic         blk_ready_q, blk_ready_d;
  logic         busy_q, busy_d;
  logic         dp_rst_n_q, dp_rst_n_d;
  logic         in_vaild_q, in_vaild_d;
  logic         compress_start_q, compress_start_d;
  logic         update_hash_q, update_hash_d;
  logic         digest_valid_q, digest_valid_d;
  logic [31:0]  k_out_q, k_out_d;
  logic         accept;
  logic         shift_en;
  logic [31:0]  load_word;
  logic [31:0]  w_t;

  assign accept = blk_valid && blk_ready_q;

`ifdef SHA256_SCHED_BSWAP_EN
  assign load_word = {blk_word[7:0], blk_word[15:8], blk_word[23:16], blk_word[31:24]};
`else
  assign load_word = blk_word;
`endif

  // Next-state, word/round counters and block flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          first_d = blk_first;
          last_d  = blk_last;
          cnt_d   = 4'd1;
          state_d = ST_LOAD;
        end else begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = first_q ? ST_INIT : ST_PRE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_INIT:  state_d = ST_PRE;
      ST_PRE: begin
        round_d = 6'd1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (round_q == 6'd63) begin
          round_d = 6'd0;
          state_d = ST_FINAL;
        end else begin
          round_d = round_q + 6'd1;
          state_d = ST_ROUND;
        end
      end
      ST_FINAL: state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default: begin
        round_d = 6'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    blk_ready_d      = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d           = (state_d != ST_IDLE);
    dp_rst_n_d       = (state_d != ST_INIT);
    in_vaild_d       = (state_d == ST_PRE) || (state_d == ST_ROUND);
    compress_start_d = (state_d == ST_ROUND) || (state_d == ST_FINAL);
    update_hash_d    = (state_d == ST_FINAL);
    digest_valid_d   = (state_d == ST_DONE);
    k_out_d          = in_vaild_d ? K_ROM[round_d] : 32'h0000_0000;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      round_q          <= 6'd0;
      first_q          <= 1'b0;
      last_q           <= 1'b0;
      blk_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      dp_rst_n_q       <= 1'b0;
      in_vaild_q       <= 1'b0;
      compress_start_q <= 1'b0;
      update_hash_q    <= 1'b0;
      digest_valid_q   <= 1'b0;
      k_out_q          <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      round_q          <= round_d;
      first_q          <= first_d;
      last_q           <= last_d;
      blk_ready_q      <= blk_ready_d;
      busy_q           <= busy_d;
      dp_rst_n_q       <= dp_rst_n_d;
      in_vaild_q       <= in_vaild_d;
      compress_start_q <= compress_start_d;
      update_hash_q    <= update_hash_d;
      digest_valid_q   <= digest_valid_d;
      k_out_q          <= k_out_d;
    end
  end

  assign shift_en = (state_q == ST_PRE) || (state_q == ST_ROUND);

  sha256_msg_sched u_msg_sched (
    .clk       (clk),
    .rst       (rst),
    .load_en   (accept),
    .load_word (load_word),
    .shift_en  (shift_en),
    .w_t       (w_t)
  );

  assign blk_ready      = blk_ready_q;
  assign busy           = busy_q;
  assign dp_rst_n       = dp_rst_n_q;
  assign in_vaild       = in_vaild_q;
  assign compress_start = compress_start_q;
  assign update_hash    = update_hash_q;
  assign digest_valid   = digest_valid_q;
  assign k_out          = k_out_q;
  assign w_out          = in_vaild_q ? w_t : 32'h0000_0000;

endmodule

// File: tb/tb_sha256_block_sched.sv
// Scoreboard bench for sha256_block_sched: a behavioural compression datapath
// consumes w_out/k_out and the strobes; digests are checked against known answers.
module tb_sha256_block_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [31:0] blk_word = 32'h0;
  logic        blk_first = 1'b0;
  logic        blk_last = 1'b0;
  logic        dp_rst_n, in_vaild, compress_start, update_hash, busy, digest_valid;
  logic [31:0] w_out, k_out;

  sha256_block_sched dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_word(blk_word), .blk_first(blk_first), .blk_last(blk_last),
    .dp_rst_n(dp_rst_n), .in_vaild(in_vaild), .compress_start(compress_start),
    .update_hash(update_hash), .w_out(w_out), .k_out(k_out), .busy(busy),
    .digest_valid(digest_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] dig;
    logic [31:0]  cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] cyc = 32'd0;
  bit          wchk = 1'b0;
  int          rnd = 0;
  logic [31:0] hm [8];
  logic [31:0] va [8];
  logic [31:0] src [8];
  logic [31:0] t1, t2;
  exp_t        e;

  localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] TWO_DIG = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] w);
`ifdef SHA256_SCHED_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Datapath model plus monitor: applies this cycle's strobes, then checks.
  always @(negedge clk) begin
    if (dp_rst_n === 1'b0) begin
      hm = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    end else begin
      if (in_vaild === 1'b1) begin
        for (int i = 0; i < 8; i++) src[i] = compress_start ? va[i] : hm[i];
        t1 = src[7] + (rr(src[4], 6) ^ rr(src[4], 11) ^ rr(src[4], 25))
           + ((src[4] & src[5]) ^ (~src[4] & src[6])) + k_out + w_out;
        t2 = (rr(src[0], 2) ^ rr(src[0], 13) ^ rr(src[0], 22))
           + ((src[0] & src[1]) ^ (src[0] & src[2]) ^ (src[1] & src[2]));
        va[7] = src[6]; va[6] = src[5]; va[5] = src[4]; va[4] = src[3] + t1;
        va[3] = src[2]; va[2] = src[1]; va[1] = src[0]; va[0] = t1 + t2;
      end
      if (update_hash === 1'b1) for (int i = 0; i < 8; i++) hm[i] = hm[i] + va[i];
    end
    if (in_vaild === 1'b1) begin
      if (compress_start === 1'b0) rnd = 0;
      else rnd++;
      if (rnd == 0) chk("k_out_r0", k_out, 32'h428a2f98);
      if (rnd == 63) chk("k_out_r63", k_out, 32'hc67178f2);
      if (wchk && rnd == 0) chk("w_out_pre", w_out, 32'h61626380);
      if (wchk && rnd == 16) chk("w16", w_out, 32'h61626380);
      if (wchk && rnd == 17) chk("w17", w_out, 32'h000f0000);
    end
    if (update_hash === 1'b1 || digest_valid === 1'b1)
      chk("ready_low_final", blk_ready, 1'b0);
    if (digest_valid === 1'b1) begin
      chk("digest_expected", 256'(exp_q.size() != 0), 256'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("digest_cycle", cyc, e.cyc);
        chk("digest", {hm[0], hm[1], hm[2], hm[3], hm[4], hm[5], hm[6], hm[7]}, e.dig);
      end
    end
  end

  task automatic send_block(input logic [31:0] wds [16], input bit first, input bit last,
                            input bit toggle, input bit has_exp, input logic [255:0] dig,
                            output logic [31:0] acc);
    int i = 0;
    int guard = 0;
    bit ph = 1'b0;
    acc = 32'd0;
    while (i < 16 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (toggle && ph) begin
        blk_valid = 1'b0;
        ph = 1'b0;
        if (i > 0) chk("busy_gap", busy, 1'b1);
      end else begin
        blk_valid = 1'b1;
        blk_word  = bus_word(wds[i]);
        blk_first = (i == 0) ? first : ~first;
        blk_last  = (i == 0) ? last : ~last;
        ph = 1'b1;
        if (blk_ready) begin
          if (i > 0) chk("busy_load", busy, 1'b1);
          if (i == 15) acc = cyc;
          i++;
        end
      end
    end
    if (i < 16) chk("load_timeout", 256'(i), 256'd16);
    @(negedge clk);
    blk_valid = 1'b0;
    if (has_exp) exp_q.push_back('{dig: dig, cyc: acc + (first ? 32'd67 : 32'd66)});
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("digest_arrived", 256'(exp_q.size()), 256'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] abc_w [16];
  logic [31:0] m1_w [16];
  logic [31:0] m2_w [16];
  logic [31:0] acc;

  initial begin
    abc_w = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    m1_w  = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m2_w  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_dp_rst_n", dp_rst_n, 1'b0);
    chk("rst_ready", blk_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {in_vaild, compress_start, update_hash, digest_valid}, 4'b0000);
    chk("rst_wk", {w_out, k_out}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("dp_rst_n_release", dp_rst_n, 1'b1);
    repeat (5) @(negedge clk);
    chk("idle_ready", blk_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_strobes", {dp_rst_n, in_vaild, compress_start, update_hash, digest_valid}, 5'b10000);
    chk("idle_wk", {w_out, k_out}, 64'h0);

    // "abc" single block with W taps
    wchk = 1'b1;
    send_block(abc_w, 1'b1, 1'b1, 1'b0, 1'b1, ABC_DIG, acc);
    wait_idle();
    wchk = 1'b0;

    // Two-block message: only the last block reports a digest
    send_block(m1_w, 1'b1, 1'b0, 1'b0, 1'b0, 256'd0, acc);
    send_block(m2_w, 1'b0, 1'b1, 1'b0, 1'b1, TWO_DIG, acc);
    wait_idle();

    // Gapped valid during load
    send_block(abc_w, 1'b1, 1'b1, 1'b1, 1'b1, ABC_DIG, acc);
    wait_idle();

    // Reset at round 30, then resend
    send_block(abc_w, 1'b1, 1'b1, 1'b0, 1'b1, ABC_DIG, acc);
    while (cyc < acc + 32'd32) @(negedge clk);
    chk("round30_active", {in_vaild, compress_start}, 2'b11);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_dp_rst_n", dp_rst_n, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_strobes", {in_vaild, compress_start, update_hash, digest_valid}, 4'b0000);
    @(negedge clk);
    chk("midrst_dp_rst_n_hold", dp_rst_n, 1'b0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_rst_ready", blk_ready, 1'b1);
    wchk = 1'b1;
    send_block(abc_w, 1'b1, 1'b1, 1'b0, 1'b1, ABC_DIG, acc);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
